// File: rtl/cnt_down_pkg.sv
// Shared definitions for the countdown timer: FSM state encodings, default sizing,
// and the prescaler width helper.
package cnt_down_pkg;

    typedef enum logic [1:0] {
        CNT_IDLE  = 2'd0,
        CNT_RUN   = 2'd1,
        CNT_PAUSE = 2'd2,
        CNT_DONE  = 2'd3
    } cnt_state_t;

    // Default prescale period, shared with the companion up counter.
    localparam int CNT_DIV_DEFAULT   = 5;
    localparam int CNT_WIDTH_DEFAULT = 4;

    // Prescaler counter width: $clog2(div), never narrower than one bit.
    function automatic int presc_width(input int div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/cnt_prescale.sv
// Clock-enable prescaler: counts 0..DIV-1 while en is high and pulses tick on DIV-1.
// clr has priority over en; with both low the count is held.
module cnt_prescale
    import cnt_down_pkg::*;
#(
    parameter int DIV = CNT_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            PW   = presc_width(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] ONE  = PW'(1);

    logic [PW-1:0] r_cnt;
    logic          w_at_last;

    assign w_at_last = (r_cnt == LAST);
    assign tick      = en & w_at_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_at_last ? '0 : r_cnt + ONE;
        end
    end

endmodule

// File: rtl/cnt_down.sv
// Programmable countdown timer with pause/restart/stop and a one-cycle done pulse.
// Build with CNT_DOWN_RELOAD_EN defined for periodic (auto-reload) operation.
module cnt_down
    import cnt_down_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEFAULT,
    parameter int DIV   = CNT_DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out1,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    cnt_state_t       r_state;
    cnt_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_out1;
    logic [WIDTH-1:0] w_out1_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_active;
    logic             w_presc_en;
    logic             w_presc_clr;
    logic             w_tick;

    // PAUSE is included so the prescaler advances on the resume edge itself.
    assign w_active    = (r_state == CNT_RUN) || (r_state == CNT_PAUSE);
    assign w_presc_en  = w_active & ~stop & ~start & ~pause;
    assign w_presc_clr = stop | start | ~w_active;

    cnt_prescale #(
        .DIV (DIV)
    ) u_prescale (
        .clk  (clk),
        .rst  (rst),
        .en   (w_presc_en),
        .clr  (w_presc_clr),
        .tick (w_tick)
    );

`ifdef CNT_DOWN_RELOAD_EN
    logic [WIDTH-1:0] r_reload;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reload <= '0;
        end else if (start && !stop) begin
            r_reload <= load_val;
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_out1_nxt  = r_out1;
        w_done_nxt  = 1'b0;

        if (stop) begin
            w_state_nxt = CNT_IDLE;
            w_out1_nxt  = '0;
        end else if (start) begin
            w_out1_nxt = load_val;
            if (load_val == '0) begin
                w_state_nxt = CNT_DONE;
                w_done_nxt  = 1'b1;
            end else begin
                w_state_nxt = CNT_RUN;
            end
        end else begin
            case (r_state)
                CNT_RUN, CNT_PAUSE: begin
                    if (pause) begin
                        w_state_nxt = CNT_PAUSE;
                    end else begin
                        w_state_nxt = CNT_RUN;
                        if (w_tick) begin
                            if (r_out1 == ONE) begin
                                w_done_nxt = 1'b1;
`ifdef CNT_DOWN_RELOAD_EN
                                w_out1_nxt  = r_reload;
`else
                                w_out1_nxt  = '0;
                                w_state_nxt = CNT_DONE;
`endif
                            end else begin
                                w_out1_nxt = r_out1 - ONE;
                            end
                        end
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end

        w_busy_nxt = (w_state_nxt == CNT_RUN) || (w_state_nxt == CNT_PAUSE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= CNT_IDLE;
            r_out1  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_out1  <= w_out1_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign out1 = r_out1;
    assign busy = r_busy;
    assign done = r_done;

endmodule
